// File: rtl/pla_pipe.sv
// Two-stage pipelined, run-time programmable sum-of-products evaluator.
// S1 registers the term match vector; S2 ORs matched terms per output and applies inversion.
module pla_pipe #(
    parameter int NUM_IN    = 28,
    parameter int NUM_TERMS = 64,
    parameter int NUM_OUT   = 3,
    parameter int TW        = $clog2(NUM_TERMS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [TW-1:0]      cfg_term,
    input  logic [NUM_IN-1:0]  cfg_care,
    input  logic [NUM_IN-1:0]  cfg_val,
    input  logic [NUM_OUT-1:0] cfg_omask,
    input  logic               inv_we,
    input  logic [NUM_OUT-1:0] inv_val,
    output logic [31:0]        vec_count
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and ready may depend on valid only through pipeline state.

    logic [NUM_IN-1:0]  care_q  [NUM_TERMS];
    logic [NUM_IN-1:0]  val_q   [NUM_TERMS];
    logic [NUM_OUT-1:0] omask_q [NUM_TERMS];
    logic [NUM_OUT-1:0] inv_q;

    logic                 s1_valid;
    logic [NUM_TERMS-1:0] s1_match;
    logic [NUM_TERMS-1:0] match;
    logic [NUM_OUT-1:0]   result;
    logic                 s1_advance;
    logic                 in_fire;
    logic                 cfg_fire;
    logic                 inv_fire;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !cfg_we && !inv_we && (!s1_valid || s1_advance);
    // Writes wait until S1 is empty so an item in S1 always resolves with the table it matched against.
    assign cfg_ready  = !s1_valid;
    assign in_fire    = in_valid && in_ready;
    assign cfg_fire   = cfg_we && cfg_ready;
    assign inv_fire   = inv_we && cfg_ready;

    always_comb begin
        match = '0;
        for (int t = 0; t < NUM_TERMS; t++) begin
            match[t] = ((in_data ^ val_q[t]) & care_q[t]) == '0;
        end
    end

    always_comb begin
        result = '0;
        for (int t = 0; t < NUM_TERMS; t++) begin
            if (s1_match[t]) begin
                result = result | omask_q[t];
            end
        end
        result = result ^ inv_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                care_q[t]  <= '0;
                val_q[t]   <= '0;
                omask_q[t] <= '0;
            end
            inv_q <= '0;
        end else begin
            if (cfg_fire) begin
                care_q[cfg_term]  <= cfg_care;
                val_q[cfg_term]   <= cfg_val;
                omask_q[cfg_term] <= cfg_omask;
            end
            if (inv_fire) begin
                inv_q <= inv_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_match <= match;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // out_data only changes when a real item moves in, so it stays stable while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= result;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vec_count <= '0;
        end else if (out_valid && out_ready) begin
            vec_count <= vec_count + 32'd1;
        end
    end

endmodule
